// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the embedded-FPGA configuration-chain loader.
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LO    = 2'd2,
    ST_HI    = 2'd3
  } cfg_state_e;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

  localparam int unsigned MM_CNT_W = 16;

  // Adds b to a and clamps at all-ones instead of wrapping.
  function automatic logic [MM_CNT_W-1:0] sat_add(input logic [MM_CNT_W-1:0] a,
                                                  input logic [MM_CNT_W-1:0] b);
    logic [MM_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MM_CNT_W] ? {MM_CNT_W{1'b1}} : sum[MM_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/fpga_cfg_clkgen.sv
// Programming-clock generator: SHIFT_DIV phase counter, registered prog_clk and
// end-of-phase strobes used by the loader FSM.
module fpga_cfg_clkgen #(
  parameter int unsigned SHIFT_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort_i,
  input  logic in_lo_i,
  input  logic in_hi_i,
  output logic lo_last_o,
  output logic hi_last_o,
  output logic prog_clk_o
);

  localparam int unsigned     PH_W    = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SHIFT_DIV - 1);

  logic [PH_W-1:0] phase_q;
  logic            prog_clk_q;
  logic            phase_last;

  assign phase_last = (phase_q == PH_LAST);
  assign lo_last_o  = in_lo_i & phase_last;
  assign hi_last_o  = in_hi_i & phase_last;
  assign prog_clk_o = prog_clk_q;

  // Phase counter: restarts at every phase boundary and whenever the shifter is not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (abort_i || phase_last || !(in_lo_i || in_hi_i)) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PH_W'(1);
    end
  end

  // prog_clk is high exactly while the FSM sits in HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_clk_q <= 1'b0;
    end else if (abort_i) begin
      prog_clk_q <= 1'b0;
    end else if (lo_last_o) begin
      prog_clk_q <= 1'b1;
    end else if (hi_last_o) begin
      prog_clk_q <= 1'b0;
    end else begin
      prog_clk_q <= prog_clk_q;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration-chain loader: streams words into NUM_CHAINS fabric config chains,
// optionally verifying against the chain tails, and gates the fabric reset.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned CHAIN_LEN  = 1024,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SHIFT_DIV  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  abort_i,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  prog_clk_o,
  output logic [NUM_CHAINS-1:0] ccff_head_o,
  input  logic [NUM_CHAINS-1:0] ccff_tail_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mismatch_o,
  output logic [MM_CNT_W-1:0]   mismatch_cnt_o,
  output logic                  fab_rst_n_o
);

  if ((NUM_CHAINS == 0) || ((DATA_W % NUM_CHAINS) != 0)) begin : g_bad_width
    $error("fpga_cfg_loader: DATA_W must be a non-zero multiple of NUM_CHAINS");
  end
  if ((SHIFT_DIV < 1) || (CHAIN_LEN < 1)) begin : g_bad_timing
    $error("fpga_cfg_loader: SHIFT_DIV and CHAIN_LEN must be at least 1");
  end

  localparam int unsigned STEPS_PER_WORD = DATA_W / NUM_CHAINS;
  localparam int unsigned IDX_W  = (STEPS_PER_WORD > 1) ? $clog2(STEPS_PER_WORD) : 1;
  localparam int unsigned STEP_W = $clog2(CHAIN_LEN + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STEPS_PER_WORD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CHAIN_LEN - 1);

  cfg_state_e            state_q;
  logic                  mode_q;
  logic [DATA_W-1:0]     word_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [STEP_W-1:0]     step_cnt_q;
  logic [NUM_CHAINS-1:0] head_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mismatch_q;
  logic [MM_CNT_W-1:0]   mm_cnt_q;
  logic                  fab_rst_n_q;

  logic                  abort_act;
  logic                  in_lo;
  logic                  in_hi;
  logic                  lo_last;
  logic                  hi_last;
  logic [DATA_W-1:0]     word_shift;
  logic [NUM_CHAINS-1:0] tail_diff;
  logic [MM_CNT_W-1:0]   diff_cnt;

  assign abort_act  = abort_i & (state_q != ST_IDLE);
  assign in_lo      = (state_q == ST_LO);
  assign in_hi      = (state_q == ST_HI);
  // The latched word is consumed LSB first, NUM_CHAINS bits per step.
  assign word_shift = word_q >> NUM_CHAINS;

  assign in_ready_o     = in_ready_q;
  assign ccff_head_o    = head_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mismatch_o     = mismatch_q;
  assign mismatch_cnt_o = mm_cnt_q;
  assign fab_rst_n_o    = fab_rst_n_q;

  fpga_cfg_clkgen #(
    .SHIFT_DIV (SHIFT_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort_i    (abort_act),
    .in_lo_i    (in_lo),
    .in_hi_i    (in_hi),
    .lo_last_o  (lo_last),
    .hi_last_o  (hi_last),
    .prog_clk_o (prog_clk_o)
  );

  // Number of chains whose tail disagrees with the bit being shifted in.
  always_comb begin
    tail_diff = ccff_tail_i ^ head_q;
    diff_cnt  = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      diff_cnt = diff_cnt + MM_CNT_W'(tail_diff[c]);
    end
  end

  // Loader FSM with registered handshake, status and fabric-reset outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_LOAD;
      word_q      <= '0;
      bit_idx_q   <= '0;
      step_cnt_q  <= '0;
      head_q      <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      mm_cnt_q    <= '0;
      fab_rst_n_q <= 1'b0;
    end else if (abort_act) begin
      // Mismatch status survives an abort so a partial verify can still be inspected.
      state_q     <= ST_IDLE;
      head_q      <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fab_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_q     <= ST_FETCH;
            mode_q      <= mode_i;
            step_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            mm_cnt_q    <= '0;
            fab_rst_n_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (in_valid_i && in_ready_q) begin
            word_q     <= in_data_i;
            bit_idx_q  <= '0;
            head_q     <= in_data_i[NUM_CHAINS-1:0];
            in_ready_q <= 1'b0;
            state_q    <= ST_LO;
          end
        end
        ST_LO: begin
          if (lo_last) begin
            if ((mode_q == MODE_VERIFY) && (diff_cnt != '0)) begin
              mismatch_q <= 1'b1;
              mm_cnt_q   <= sat_add(mm_cnt_q, diff_cnt);
            end
            state_q <= ST_HI;
          end
        end
        ST_HI: begin
          if (hi_last) begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
            if (step_cnt_q == STEP_LAST) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              fab_rst_n_q <= !((mode_q == MODE_VERIFY) && mismatch_q);
            end else if (bit_idx_q == IDX_LAST) begin
              state_q    <= ST_FETCH;
              in_ready_q <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              word_q    <= word_shift;
              head_q    <= word_shift[NUM_CHAINS-1:0];
              state_q   <= ST_LO;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
